// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder/subtractor reusing one full-adder cell over WIDTH cycles
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic             cell_s;
    logic             cell_co;
    logic [WIDTH-1:0] sr_next;
    logic             last_bit;

    // The single shared full-adder cell
    assign cell_s   = sa_q[0] ^ sb_q[0] ^ carry_q;
    assign cell_co  = (sa_q[0] & sb_q[0]) | (carry_q & (sa_q[0] ^ sb_q[0]));
    assign sr_next  = {cell_s, sr_q[WIDTH-1:1]};
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sr_d    = sr_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    // Subtraction is A + ~B + 1: invert B and seed the carry with 1
                    sa_d    = a;
                    sb_d    = sub ? ~b : b;
                    sr_d    = '0;
                    cnt_d   = '0;
                    carry_d = sub;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                sr_d    = sr_next;
                sa_d    = sa_q >> 1;
                sb_d    = sb_q >> 1;
                carry_d = cell_co;
                cnt_d   = cnt_q + CW'(1);
                if (last_bit) begin
                    // carry_q is the carry into the MSB on this step
                    sum_d   = sr_next;
                    cout_d  = cell_co;
                    ovf_d   = carry_q ^ cell_co;
                    zero_d  = (sr_next == '0);
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sr_q    <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sr_q    <= sr_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - randomized self-checking bench for serial_add_ctrl
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, cout, ovf, zero;
    logic [W-1:0] sum;

    int errors = 0;
    int checks = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .sub  (sub),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout),
        .ovf  (ovf),
        .zero (zero)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Integer arithmetic reference: wrapped result, unsigned carry/no-borrow, signed range overflow
    function automatic void model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] r, output logic c, output logic v,
                                  output logic z);
        int ux, uy, sx, sy, sres;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (s) begin
            r    = W'(ux - uy);
            c    = (ux >= uy);
            sres = sx - sy;
        end else begin
            r    = W'(ux + uy);
            c    = ((ux + uy) >= (1 << W));
            sres = sx + sy;
        end
        v = (sres > ((1 << (W - 1)) - 1)) || (sres < -(1 << (W - 1)));
        z = (r == '0);
    endfunction

    task automatic start_op(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        start = 1'b1;
        sub   = s;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        sub   = 1'($urandom);
        a     = W'($urandom);
        b     = W'($urandom);
    endtask

    // Returns edges from the accepting edge to done, busy samples (incl. the E0 sample), busy&done overlaps
    task automatic wait_done(output int n, output int busy_n, output int overlap);
        n       = 0;
        busy_n  = busy ? 1 : 0;
        overlap = 0;
        while (n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (busy && done) overlap++;
            if (done) break;
            if (busy) busy_n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, sum, cout, ovf, zero} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", {busy, done, sum, cout, ovf, zero});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle: busy/done got %b expected 00", {busy, done});
        end
    endtask

    task automatic test_directed();
        logic          ops_s [5];
        logic [W-1:0]  ops_a [5];
        logic [W-1:0]  ops_b [5];
        logic [W+2:0]  exp_r [5];
        int n, bn, ov;
        ops_s = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        ops_a = '{8'h5A, 8'hFF, 8'h10, 8'h80, 8'h37};
        ops_b = '{8'h33, 8'h01, 8'h20, 8'h01, 8'h37};
        // {sum, cout, ovf, zero}
        exp_r = '{{8'h8D, 3'b010}, {8'h00, 3'b101}, {8'hF0, 3'b000},
                  {8'h7F, 3'b110}, {8'h00, 3'b101}};
        for (int i = 0; i < 5; i++) begin
            start_op(ops_s[i], ops_a[i], ops_b[i]);
            wait_done(n, bn, ov);
            checks++;
            if (n !== 8 || bn !== 8 || ov !== 0) begin
                errors++;
                $display("FAIL directed_timing[%0d]: latency=%0d busy=%0d overlap=%0d expected 8/8/0",
                         i, n, bn, ov);
            end
            checks++;
            if ({sum, cout, ovf, zero} !== exp_r[i]) begin
                errors++;
                $display("FAIL directed_result[%0d]: got %h expected %h", i,
                         {sum, cout, ovf, zero}, exp_r[i]);
            end
            @(posedge clk);
            #1;
            checks++;
            if ({busy, done} !== 2'b00) begin
                errors++;
                $display("FAIL directed_return_idle[%0d]: busy/done got %b expected 00", i, {busy, done});
            end
        end
    endtask

    task automatic test_ignore_start();
        int ndone, done_at, bn;
        ndone   = 0;
        done_at = -1;
        start_op(1'b0, 8'h01, 8'h02);
        bn = busy ? 1 : 0;
        for (int k = 1; k <= 12; k++) begin
            if (k == 3) begin
                @(negedge clk);
                start = 1'b1;
                sub   = 1'b0;
                a     = 8'hFF;
                b     = 8'hFF;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                ndone++;
                if (done_at < 0) done_at = k;
            end
            if (busy) bn++;
        end
        checks++;
        if (ndone !== 1 || done_at !== 8) begin
            errors++;
            $display("FAIL ignore_start_done: count=%0d at=%0d expected 1 at 8", ndone, done_at);
        end
        checks++;
        if (bn !== 8) begin
            errors++;
            $display("FAIL ignore_start_busy: busy cycles=%0d expected 8", bn);
        end
        checks++;
        if (sum !== 8'h03) begin
            errors++;
            $display("FAIL ignore_start_sum: got %h expected 03", sum);
        end
    endtask

    task automatic test_back_to_back();
        int n, bn, ov, held_err;
        start_op(1'b1, 8'h37, 8'h37);
        wait_done(n, bn, ov);
        checks++;
        if (n !== 8 || {sum, zero} !== {8'h00, 1'b1}) begin
            errors++;
            $display("FAIL b2b_first: latency=%0d sum=%h zero=%b expected 8/00/1", n, sum, zero);
        end
        start_op(1'b0, 8'h7F, 8'h01);
        checks++;
        if ({busy, done, sum, zero} !== {1'b1, 1'b0, 8'h00, 1'b1}) begin
            errors++;
            $display("FAIL b2b_reenter: busy=%b done=%b sum=%h zero=%b expected 1/0/00/1",
                     busy, done, sum, zero);
        end
        n        = 0;
        held_err = 0;
        while (n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
            if (sum !== 8'h00) held_err++;
        end
        checks++;
        if (held_err !== 0 || n !== 8) begin
            errors++;
            $display("FAIL b2b_hold: held_errors=%0d latency=%0d expected 0/8", held_err, n);
        end
        checks++;
        if ({sum, cout, ovf, zero} !== {8'h80, 3'b010}) begin
            errors++;
            $display("FAIL b2b_result: got %h expected %h", {sum, cout, ovf, zero}, {8'h80, 3'b010});
        end
    endtask

    task automatic test_reset_mid();
        int n, bn, ov;
        logic [W-1:0] r;
        logic c, v, z;
        start_op(1'b0, 8'h5A, 8'h33);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, sum, cout, ovf, zero} !== '0) begin
            errors++;
            $display("FAIL reset_mid_immediate: got %h expected 0", {busy, done, sum, cout, ovf, zero});
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, sum, cout, ovf, zero} !== '0) begin
            errors++;
            $display("FAIL reset_mid_hold: got %h expected 0", {busy, done, sum, cout, ovf, zero});
        end
        @(negedge clk);
        rst_n = 1'b1;
        start_op(1'b0, 8'h0F, 8'h01);
        wait_done(n, bn, ov);
        model(1'b0, 8'h0F, 8'h01, r, c, v, z);
        checks++;
        if (n !== 8 || {sum, cout, ovf, zero} !== {8'h10, c, v, z}) begin
            errors++;
            $display("FAIL reset_mid_fresh: latency=%0d got %h expected 8 / %h", n,
                     {sum, cout, ovf, zero}, {8'h10, c, v, z});
        end
    endtask

    task automatic test_random();
        int n, bn, ov, gap, pick;
        logic         s, c, v, z;
        logic [W-1:0] x, y, r;
        for (int i = 0; i < 60; i++) begin
            s    = 1'($urandom);
            pick = $urandom_range(0, 5);
            x    = (pick == 0) ? 8'h80 : (pick == 1) ? 8'h7F : (pick == 2) ? 8'hFF : W'($urandom);
            pick = $urandom_range(0, 5);
            y    = (pick == 0) ? 8'h01 : (pick == 1) ? x : (pick == 2) ? 8'h00 : W'($urandom);
            gap  = $urandom_range(0, 2);
            if (gap > 0) repeat (gap) @(posedge clk);
            start_op(s, x, y);
            wait_done(n, bn, ov);
            model(s, x, y, r, c, v, z);
            checks++;
            if (n !== 8 || bn !== 8 || ov !== 0) begin
                errors++;
                $display("FAIL random_timing[%0d]: latency=%0d busy=%0d overlap=%0d expected 8/8/0",
                         i, n, bn, ov);
            end
            checks++;
            if ({sum, cout, ovf, zero} !== {r, c, v, z}) begin
                errors++;
                $display("FAIL random_result[%0d] sub=%b a=%h b=%h: got %h expected %h", i, s, x, y,
                         {sum, cout, ovf, zero}, {r, c, v, z});
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial N-bit adder/subtractor controller that time-multiplexes a single 1-bit full-adder cell (ia, ib, cin -> sum, cout) over WIDTH clock cycles. It captures two operands on a start request and feeds one bit pair per cycle, LSB first, into the cell. It holds the carry in a flip-flop between bits and assembles the result in a shift register. It sits between the datapath register file and the ALU result bus as the low-area alternative to a WIDTH-bit ripple adder.

## Interface
- WIDTH, 8, operand/result width in bits (>= 2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled on rising edge; accepted only in IDLE or DONE
- sub  input  1  0 = A+B, 1 = A-B; sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; results valid from this cycle
- sum  output  WIDTH  result, held until the next completion
- cout  output  1  carry out of the MSB (for sub: 1 = no borrow)
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB
- zero  output  1  sum == 0

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE/DONE with start=1: load A into shift reg sa, load (sub ? ~b : b) into sb. Set carry flip-flop to sub, bit counter to 0, sub-flag register to sub. Go to RUN.
- IDLE/DONE with start=0: go to IDLE.
- RUN, each cycle:
  - cell inputs are ia=sa[0], ib=sb[0], cin=carry.
  - cell sum shifts into the MSB of the result shift reg sr; sa and sb shift right.
  - carry <= cell cout. On the MSB step, also capture the cell cin as the carry-into-MSB.
  - counter increments.
- RUN with counter == WIDTH-1: on that edge, write sum <= final sr value, cout <= cell cout, ovf <= cin_msb ^ cell cout, zero <= (final sum == 0). Go to DONE.
- start while in RUN is ignored (not queued). a, b and sub may change freely after the accepting edge.
- Arithmetic is modulo 2^WIDTH. Subtraction is A + ~B + 1 through the same cell. No other arithmetic path exists.
- Back-to-back operation: start asserted during the DONE cycle is accepted and goes directly to RUN. Outputs keep the previous result until the new completion.
- Reset mid-operation, at any time: immediately goes to IDLE and clears all state and outputs. The partial result is discarded.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0, ovf=0, zero=0. State IDLE; internal registers 0.
- Edge E0 samples start=1. busy=1 is visible after E0.
- Edges E1..EWIDTH each process one bit, LSB first.
- After EWIDTH: state DONE, done=1, busy=0, sum/cout/ovf/zero valid.
- After EWIDTH+1: done=0. State is IDLE, or RUN if start was sampled at EWIDTH+1.
- Latency is WIDTH edges from the accepting edge to done; throughput is one operation per WIDTH+1 cycles.
- busy and done are never high together. done is high for exactly one cycle per accepted start.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- WIDTH=8, add 0x5A+0x33 -> done exactly 8 cycles after the start edge; sum=0x8D, cout=0, ovf=1, zero=0.
- add 0xFF+0x01 -> sum=0x00, cout=1, ovf=0, zero=1. Then sub 0x10-0x20 -> sum=0xF0, cout=0, ovf=0, zero=0.
- sub 0x80-0x01 -> sum=0x7F, cout=1, ovf=1. Then sub 0x37-0x37 -> sum=0x00, cout=1, zero=1.
- Start 0x01+0x02, then pulse start with 0xFF+0xFF at cycle 3 of RUN -> one done only; sum=0x03. busy stays high for exactly 8 cycles.
- Start asserted in the DONE cycle with new operands 0x7F+0x01 -> RUN re-entered without an IDLE cycle. Previous sum is held until the new done; new sum=0x80, ovf=1.
- Drop rst_n at cycle 4 of RUN -> busy, done and all outputs go to 0 immediately and state is IDLE. After release, a fresh 0x0F+0x01 gives sum=0x10.
